// File: rtl/axi_interconnect_default_slave.sv
// Default slave for the crossbar's spare master port. Accepts any request
// routed to an unmapped address, swallows the whole transaction and answers
// with DECERR: one B response for writes, LEN+1 R beats for reads.
// Only one transaction is in flight at a time.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for an address; s_addr_ready high
// ST_WDATA | write only: discarding W beats until wlast is accepted
// ST_RESP  | driving DECERR responses until the last one is accepted
module axi_interconnect_default_slave #(
    parameter int MODE_READ      = 1,
    parameter int WIDTH_ADDR     = 32,
    parameter int WIDTH_ID       = 4,
    parameter int WIDTH_ADDRINFO = 64,
    parameter int WIDTH_DATAINFO = 48,
    parameter int WIDTH_RESPINFO = 48,
    parameter int U_DLY          = 1
) (
    input  logic                      clk_sys,
    input  logic                      rst_n,
    input  logic [WIDTH_ADDRINFO-1:0] s_addr_info,
    input  logic                      s_addr_valid,
    output logic                      s_addr_ready,
    input  logic [WIDTH_DATAINFO-1:0] s_wdata_info,
    input  logic                      s_wdata_valid,
    output logic                      s_wdata_ready,
    output logic [WIDTH_RESPINFO-1:0] s_resp_info,
    output logic                      s_resp_valid,
    input  logic                      s_resp_ready
);

    localparam bit IS_READ = (MODE_READ != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    if (WIDTH_ADDRINFO < WIDTH_ADDR + 8 + WIDTH_ID) begin : g_chk_addrinfo
        $error("WIDTH_ADDRINFO too small for addr/len/id fields");
    end
    if (WIDTH_RESPINFO < 3 + WIDTH_ID) begin : g_chk_respinfo
        $error("WIDTH_RESPINFO too small for resp/last/id fields");
    end

    state_t              state_q;
    state_t              state_nxt;
    logic [7:0]          cnt_q;
    logic [7:0]          cnt_nxt;
    logic [WIDTH_ID-1:0] id_q;
    logic [WIDTH_ID-1:0] id_nxt;
    logic                last_q;
    logic                last_nxt;
    logic [1:0]          resp_q;

    logic [7:0]          addr_len;
    logic [WIDTH_ID-1:0] addr_id;
    logic                wlast;

    assign addr_len = s_addr_info[WIDTH_ADDR +: 8];
    assign addr_id  = s_addr_info[WIDTH_ADDR + 8 +: WIDTH_ID];
    assign wlast    = s_wdata_info[WIDTH_DATAINFO-1];

    // Address, payload and the simulation-delay parameter are not consumed.
    logic unused_inputs;
    assign unused_inputs = ^{s_addr_info, s_wdata_info, s_wdata_valid, (U_DLY != 0)};

    // Next-state, beat counter and latched-ID decode.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        id_nxt    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (s_addr_valid && s_addr_ready) begin
                    id_nxt    = addr_id;
                    cnt_nxt   = addr_len;
                    state_nxt = IS_READ ? ST_RESP : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (s_wdata_valid && s_wdata_ready && wlast) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (s_resp_valid && s_resp_ready) begin
                    if (!IS_READ || cnt_q == 8'd0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt_q - 8'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A write has a single B beat, so it is always the last one.
        last_nxt = IS_READ ? (cnt_nxt == 8'd0) : 1'b1;
    end

    // State register plus registered handshake and response outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            id_q          <= '0;
            last_q        <= 1'b0;
            resp_q        <= 2'b00;
            s_addr_ready  <= 1'b0;
            s_wdata_ready <= 1'b0;
            s_resp_valid  <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            cnt_q         <= cnt_nxt;
            id_q          <= id_nxt;
            last_q        <= (state_nxt == ST_RESP) && last_nxt;
            resp_q        <= (state_nxt == ST_RESP) ? 2'b11 : 2'b00;
            s_addr_ready  <= (state_nxt == ST_IDLE);
            s_wdata_ready <= !IS_READ && (state_nxt == ST_WDATA);
            s_resp_valid  <= (state_nxt == ST_RESP);
        end
    end

    // Pack the flopped fields into the response bus; upper bits stay zero.
    always_comb begin
        s_resp_info                 = '0;
        s_resp_info[1:0]            = resp_q;
        s_resp_info[2]              = last_q;
        s_resp_info[3 +: WIDTH_ID]  = id_q;
    end

endmodule
